// File: rtl/demux_pkg.sv
// demux_pkg: shared limits, select-width helper and one-hot select type for the demux family
package demux_pkg;
   localparam int DEMUX_N_OUT_MAX = 16;
   typedef logic [DEMUX_N_OUT_MAX-1:0] onehot_t;
   function automatic int sel_w(input int n);
      return $clog2(n);
   endfunction
endpackage

// File: rtl/demux_sel_decoder.sv
// demux_sel_decoder: binary select to N_OUT-bit one-hot lane enable
//   S  : binary lane select
//   en : one-hot enable; all-zero for out-of-range or unknown S
module demux_sel_decoder
   import demux_pkg::*;
#(
   parameter int N_OUT = 4,
   parameter int SEL_W = sel_w(N_OUT)
) (
   input  logic [SEL_W-1:0] S,
   output logic [N_OUT-1:0] en
);
   // An unknown S makes every if-condition false, so en stays zero rather than X.
   always_comb begin
      en = '0;
      for (int k = 0; k < N_OUT; k++)
         if (S == SEL_W'(k)) en[k] = 1'b1;
   end
endmodule

// File: rtl/demultiplexer_1_4.sv
// demultiplexer_1_4: routes D to lane S of Y, all other lanes zero; optional registered output
//   clk   : clock, only used when REGISTERED=1
//   rst_n : asynchronous active-low reset, forces Y to zero
//   D     : data to route
//   S     : binary lane select
//   Y     : lane k at bits [k*DATA_W +: DATA_W]
module demultiplexer_1_4
   import demux_pkg::*;
#(
   parameter int DATA_W     = 1,
   parameter int N_OUT      = 4,
   parameter int SEL_W      = sel_w(N_OUT),
   parameter bit REGISTERED = 1'b0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       D,
   input  logic [SEL_W-1:0]        S,
   output logic [N_OUT*DATA_W-1:0] Y
);
   if (N_OUT < 2 || N_OUT > DEMUX_N_OUT_MAX) begin : g_bad_n_out
      $error("demultiplexer_1_4: N_OUT must be in 2..16");
   end
   if (SEL_W < $clog2(N_OUT)) begin : g_bad_sel_w
      $error("demultiplexer_1_4: SEL_W too narrow for N_OUT");
   end
   logic [N_OUT-1:0]        en;
   logic [N_OUT*DATA_W-1:0] lanes;
   demux_sel_decoder #(.N_OUT(N_OUT), .SEL_W(SEL_W)) u_dec (.S(S), .en(en));
   for (genvar g = 0; g < N_OUT; g++) begin : g_lane
      assign lanes[g*DATA_W +: DATA_W] = D & {DATA_W{en[g]}};
   end
   if (REGISTERED) begin : g_reg
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) Y <= '0;
         else        Y <= lanes;
   end else begin : g_comb
      logic unused_clk;
      assign unused_clk = clk;
      assign Y = rst_n ? lanes : '0;
   end
endmodule

// File: tb/tb_demultiplexer_1_4.sv
// tb_demultiplexer_1_4: directed and random checks of combinational, registered and wide builds
module tb_demultiplexer_1_4;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        d;
   logic [1:0]  s;
   logic [3:0]  y_c, y_r;
   logic [7:0]  d8;
   logic [2:0]  s3;
   logic [39:0] y_w;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   demultiplexer_1_4 u_comb (.clk(clk), .rst_n(rst_n), .D(d), .S(s), .Y(y_c));
   demultiplexer_1_4 #(.REGISTERED(1'b1)) u_reg (.clk(clk), .rst_n(rst_n), .D(d), .S(s), .Y(y_r));
   demultiplexer_1_4 #(.DATA_W(8), .N_OUT(5)) u_wide (.clk(clk), .rst_n(rst_n), .D(d8), .S(s3), .Y(y_w));

   task automatic test_reset;
      rst_n = 1'b0; d = 1'b1; s = 2'd3; d8 = 8'hA5; s3 = 3'd4;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (y_c !== 4'b0000) begin errors++; $display("FAIL reset_comb got %b want 0000", y_c); end
      checks++; if (y_r !== 4'b0000) begin errors++; $display("FAIL reset_reg got %b want 0000", y_r); end
      checks++; if (y_w !== 40'h0) begin errors++; $display("FAIL reset_wide got %h want 0", y_w); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (y_c !== 4'b1000) begin errors++; $display("FAIL release_comb got %b want 1000", y_c); end
      checks++; if (y_r !== 4'b0000) begin errors++; $display("FAIL release_reg_noedge got %b want 0000", y_r); end
      checks++; if (y_w !== 40'hA500000000) begin errors++; $display("FAIL release_wide got %h want a500000000", y_w); end
      @(posedge clk);
      #1;
      checks++; if (y_r !== 4'b1000) begin errors++; $display("FAIL release_reg_edge got %b want 1000", y_r); end
   endtask

   task automatic test_onehot;
      logic [3:0] exp_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      d = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s = 2'(i);
         #5;
         checks++; if (y_c !== exp_tbl[i]) begin errors++; $display("FAIL onehot s=%0d got %b want %b", i, y_c, exp_tbl[i]); end
      end
   endtask

   task automatic test_zero_data;
      d = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s = 2'(i);
         #5;
         checks++; if (y_c !== 4'b0000) begin errors++; $display("FAIL zero_data s=%0d got %b want 0000", i, y_c); end
      end
      s = 2'd2;
      #1;
      checks++; if (y_c !== 4'b0000) begin errors++; $display("FAIL zero_data_s2 got %b want 0000", y_c); end
      d = 1'b1;
      #1;
      checks++; if (y_c !== 4'b0100) begin errors++; $display("FAIL data_toggle got %b want 0100", y_c); end
   endtask

   task automatic test_registered;
      @(negedge clk);
      d = 1'b1; s = 2'd1;
      @(posedge clk);
      #1;
      checks++; if (y_r !== 4'b0010) begin errors++; $display("FAIL reg_s1 got %b want 0010", y_r); end
      #1;
      s = 2'd2;
      #2;
      checks++; if (y_r !== 4'b0010) begin errors++; $display("FAIL reg_hold got %b want 0010", y_r); end
      checks++; if (y_c !== 4'b0100) begin errors++; $display("FAIL comb_s2 got %b want 0100", y_c); end
      @(posedge clk);
      #1;
      checks++; if (y_r !== 4'b0100) begin errors++; $display("FAIL reg_s2 got %b want 0100", y_r); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (y_r !== 4'b0000) begin errors++; $display("FAIL reg_midreset got %b want 0000", y_r); end
      checks++; if (y_c !== 4'b0000) begin errors++; $display("FAIL comb_midreset got %b want 0000", y_c); end
      @(posedge clk);
      #1;
      checks++; if (y_r !== 4'b0000) begin errors++; $display("FAIL reg_reset_hold got %b want 0000", y_r); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (y_r !== 4'b0100) begin errors++; $display("FAIL reg_after_reset got %b want 0100", y_r); end
   endtask

   task automatic test_wide;
      logic [39:0] exp_tbl [8] = '{40'h00000000A5, 40'h000000A500, 40'h0000A50000, 40'h00A5000000,
                                   40'hA500000000, 40'h0, 40'h0, 40'h0};
      d8 = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         s3 = 3'(i);
         #1;
         checks++; if (y_w !== exp_tbl[i]) begin errors++; $display("FAIL wide s=%0d got %h want %h", i, y_w, exp_tbl[i]); end
      end
      d8 = 8'h3C; s3 = 3'd2;
      #1;
      checks++; if (y_w !== 40'h00003C0000) begin errors++; $display("FAIL wide_3c got %h want 00003c0000", y_w); end
   endtask

   task automatic test_x_select;
      d = 1'b1; s = 2'bxx; d8 = 8'hFF; s3 = 3'bxxx;
      #1;
      if ($isunknown(s)) begin
         checks++; if (y_c !== 4'b0000) begin errors++; $display("FAIL x_sel_comb got %b want 0000", y_c); end
      end
      if ($isunknown(s3)) begin
         checks++; if (y_w !== 40'h0) begin errors++; $display("FAIL x_sel_wide got %h want 0", y_w); end
      end
   endtask

   task automatic test_random;
      logic [39:0] exp_w;
      logic [3:0]  exp_r;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         d = 1'($urandom); s = 2'($urandom); d8 = 8'($urandom); s3 = 3'($urandom);
         exp_w = (s3 < 3'd5) ? (40'(d8) << (32'(s3) * 8)) : 40'h0;
         exp_r = 4'(d) << s;
         #1;
         checks++; if (y_w !== exp_w) begin errors++; $display("FAIL rand_wide d=%h s=%0d got %h want %h", d8, s3, y_w, exp_w); end
         checks++; if (y_c !== exp_r) begin errors++; $display("FAIL rand_comb d=%b s=%0d got %b want %b", d, s, y_c, exp_r); end
         @(posedge clk);
         #1;
         checks++; if (y_r !== exp_r) begin errors++; $display("FAIL rand_reg d=%b s=%0d got %b want %b", d, s, y_r, exp_r); end
      end
   endtask

   initial begin
      test_reset;
      test_onehot;
      test_zero_data;
      test_registered;
      test_wide;
      test_x_select;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
